// File: rtl/bus_ctrl_pkg.sv
// Shared definitions for the hardwired bus sequencer: states, opcode classes,
// bus-source bit positions and fault codes.
package bus_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5,
    S_T6, S_T6W, S_T7, S_T7W, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU_R, CLS_ALU_I, CLS_MULDIV, CLS_LD, CLS_ST, CLS_NOP, CLS_HALT, CLS_ILL
  } op_class_t;

  localparam logic [4:0] OP_ADD         = 5'h00;
  localparam logic [4:0] OP_ALU_R_LAST  = 5'h08;
  localparam logic [4:0] OP_ALU_I_FIRST = 5'h0C;
  localparam logic [4:0] OP_ALU_I_LAST  = 5'h0E;
  localparam logic [4:0] OP_MUL         = 5'h0F;
  localparam logic [4:0] OP_DIV         = 5'h10;
  localparam logic [4:0] OP_LD          = 5'h11;
  localparam logic [4:0] OP_ST          = 5'h12;
  localparam logic [4:0] OP_NOP         = 5'h1A;
  localparam logic [4:0] OP_HALT        = 5'h1B;

  localparam int SRC_R0     = 0;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_C      = 23;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  function automatic op_class_t op_class(input logic [4:0] op);
    if (op <= OP_ALU_R_LAST)                          return CLS_ALU_R;
    if (op >= OP_ALU_I_FIRST && op <= OP_ALU_I_LAST)  return CLS_ALU_I;
    if (op == OP_MUL || op == OP_DIV)                 return CLS_MULDIV;
    if (op == OP_LD)                                  return CLS_LD;
    if (op == OP_ST)                                  return CLS_ST;
    if (op == OP_NOP)                                 return CLS_NOP;
    if (op == OP_HALT)                                return CLS_HALT;
    return CLS_ILL;
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Memory wait counter: held at zero outside wait states, counts cycles without
// mem_ready, flags a timeout on the cycle the count would reach WAIT_LIMIT.
module seq_wait_timer
  import bus_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 8
) (
  input  logic clock,
  input  logic clear,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or posedge clear) begin
    if (clear)           cnt <= '0;
    else if (!active)    cnt <= '0;
    else if (!mem_ready) cnt <= cnt + 1'b1;
  end

  // The request is held for exactly WAIT_LIMIT unanswered cycles.
  assign timeout = active && !mem_ready && (cnt == CNT_W'(WAIT_LIMIT - 1));

endmodule

// File: rtl/bus_sequencer.sv
// Hardwired control-step sequencer: one bus source per cycle, load enables,
// ALU opcode and memory handshake for fetch/decode/execute.
module bus_sequencer
  import bus_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 8
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic [23:0] bus_src,
  output logic [15:0] reg_in,
  output logic        pc_in,
  output logic        ir_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        y_in,
  output logic        z_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic        mdr_sel,
  output logic        inc_pc,
  output logic [4:0]  alu_op,
  output logic        mem_read,
  output logic        mem_write,
  output logic        done,
  output logic        halted,
  output logic [1:0]  fault
);

  state_t     state, state_next, instr_end;
  logic [1:0] fault_q, fault_next;
  op_class_t  cls;
  logic [4:0] opc;
  logic [3:0] ra, rb, rc;
  logic       waiting, timeout;
  logic       unused_ir;

  assign opc       = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign unused_ir = ^ir[14:0];
  assign cls       = op_class(opc);
  assign waiting   = (state == S_T1W) || (state == S_T6W) || (state == S_T7W);
  assign instr_end = run ? S_T0 : S_IDLE;

  seq_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) u_timer (
    .clock(clock), .clear(clear), .active(waiting),
    .mem_ready(mem_ready), .timeout(timeout)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state   <= S_IDLE;
      fault_q <= FAULT_NONE;
    end else begin
      state   <= state_next;
      fault_q <= fault_next;
    end
  end

  always_comb begin
    state_next = state;
    fault_next = fault_q;
    case (state)
      S_IDLE: if (run) state_next = S_T0;
      S_T0:   state_next = S_T1;
      S_T1:   state_next = S_T1W;
      S_T2:   state_next = S_T3;
      S_T4:   state_next = S_T5;
      S_T7:   state_next = instr_end;
      S_T3: begin
        case (cls)
          CLS_NOP:  state_next = instr_end;
          CLS_HALT: state_next = S_HALT;
          CLS_ILL: begin
            state_next = S_HALT;
            fault_next = FAULT_ILLEGAL;
          end
          default:  state_next = S_T4;
        endcase
      end
      S_T5: begin
        case (cls)
          CLS_ALU_R, CLS_ALU_I: state_next = instr_end;
          CLS_LD:               state_next = S_T6W;
          default:              state_next = S_T6;
        endcase
      end
      S_T6: state_next = (cls == CLS_ST) ? S_T7W : instr_end;
      S_T1W, S_T6W, S_T7W: begin
        if (mem_ready) begin
          if (state == S_T1W)      state_next = S_T2;
          else if (state == S_T6W) state_next = S_T7;
          else                     state_next = instr_end;
        end else if (timeout) begin
          state_next = S_HALT;
          fault_next = FAULT_TIMEOUT;
        end
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus_src = '0; reg_in = '0;
    pc_in = 1'b0; ir_in = 1'b0; mar_in = 1'b0; mdr_in = 1'b0;
    y_in = 1'b0; z_in = 1'b0; hi_in = 1'b0; lo_in = 1'b0;
    mdr_sel = 1'b0; inc_pc = 1'b0; alu_op = '0;
    mem_read = 1'b0; mem_write = 1'b0; done = 1'b0; halted = 1'b0;
    fault = fault_q;
    case (state)
      S_T0: begin
        bus_src[SRC_PC] = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
      end
      S_T1: begin
        bus_src[SRC_ZLO] = 1'b1; pc_in = 1'b1; mem_read = 1'b1;
      end
      S_T1W, S_T6W: begin
        mem_read = 1'b1;
        mdr_in   = mem_ready;
        mdr_sel  = mem_ready;
      end
      S_T2: begin
        bus_src[SRC_MDR] = 1'b1; ir_in = 1'b1;
      end
      S_T3: begin
        case (cls)
          CLS_MULDIV: begin bus_src[SRC_R0 + 5'(ra)] = 1'b1; y_in = 1'b1; end
          CLS_NOP:    done = 1'b1;
          CLS_HALT, CLS_ILL: ;
          default:    begin bus_src[SRC_R0 + 5'(rb)] = 1'b1; y_in = 1'b1; end
        endcase
      end
      S_T4: begin
        z_in   = 1'b1;
        alu_op = opc;
        case (cls)
          CLS_ALU_R:  bus_src[SRC_R0 + 5'(rc)] = 1'b1;
          CLS_MULDIV: bus_src[SRC_R0 + 5'(rb)] = 1'b1;
          CLS_LD, CLS_ST: begin bus_src[SRC_C] = 1'b1; alu_op = OP_ADD; end
          default:    bus_src[SRC_C] = 1'b1;
        endcase
      end
      S_T5: begin
        bus_src[SRC_ZLO] = 1'b1;
        case (cls)
          CLS_ALU_R, CLS_ALU_I: begin reg_in[ra] = 1'b1; done = 1'b1; end
          CLS_MULDIV:           lo_in = 1'b1;
          default:              mar_in = 1'b1;
        endcase
      end
      S_T6: begin
        if (cls == CLS_ST) begin
          bus_src[SRC_R0 + 5'(ra)] = 1'b1; mdr_in = 1'b1;
        end else begin
          bus_src[SRC_ZHI] = 1'b1; hi_in = 1'b1; done = 1'b1;
        end
      end
      S_T7: begin
        bus_src[SRC_MDR] = 1'b1; reg_in[ra] = 1'b1; done = 1'b1;
      end
      S_T7W: begin
        mem_write = 1'b1;
        done      = mem_ready;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer: per-cycle expected-output table plus
// hand sequences for timeout, illegal/HALT opcodes and asynchronous clear.
module tb_bus_sequencer;

  logic        clock, clear, run, mem_ready;
  logic [31:0] ir;
  logic [23:0] bus_src;
  logic [15:0] reg_in;
  logic        pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in;
  logic        mdr_sel, inc_pc, mem_read, mem_write, done, halted;
  logic [4:0]  alu_op;
  logic [1:0]  fault;

  int n_chk  = 0;
  int n_fail = 0;

  bus_sequencer dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
    .bus_src(bus_src), .reg_in(reg_in), .pc_in(pc_in), .ir_in(ir_in),
    .mar_in(mar_in), .mdr_in(mdr_in), .y_in(y_in), .z_in(z_in),
    .hi_in(hi_in), .lo_in(lo_in), .mdr_sel(mdr_sel), .inc_pc(inc_pc),
    .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write),
    .done(done), .halted(halted), .fault(fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Flag order: pc,ir,mar,mdr,y,z,hi,lo,mdr_sel,inc_pc,rd,wr,done,halted
  localparam logic [13:0] PCI = 14'h2000, IRI = 14'h1000, MARI = 14'h0800,
                          MDRI = 14'h0400, YI = 14'h0200, ZI = 14'h0100,
                          HII = 14'h0080, LOI = 14'h0040, SEL = 14'h0020,
                          INC = 14'h0010, RD = 14'h0008, WR = 14'h0004,
                          DN = 14'h0002, HLT = 14'h0001;

  localparam logic [31:0] I_ADD  = 32'h0091_8000;  // ADD R1,R2,R3
  localparam logic [31:0] I_LD   = 32'h8A10_0005;  // LD R4,5(R2)
  localparam logic [31:0] I_ST   = 32'h9210_0005;  // ST R4,5(R2)
  localparam logic [31:0] I_MUL  = 32'h7AB0_0000;  // MUL R5,R6
  localparam logic [31:0] I_ADDI = 32'h6090_0000;  // op 0x0C R1,R2
  localparam logic [31:0] I_NOP  = 32'hD000_0000;
  localparam logic [31:0] I_HALT = 32'hD800_0000;
  localparam logic [31:0] I_BAD  = 32'hF800_0000;

  typedef struct {
    logic        run;
    logic        rdy;
    logic [31:0] ir;
    logic [60:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [23:0] B(input int n);
    logic [23:0] one;
    one = 24'd1;
    return one << n;
  endfunction

  function automatic vec_t mk(input logic r, input logic m, input logic [31:0] i,
                              input logic [23:0] b, input logic [15:0] rg,
                              input logic [13:0] f, input logic [4:0] a,
                              input logic [1:0] ft);
    vec_t v;
    v.run = r; v.rdy = m; v.ir = i;
    v.exp = {b, rg, f, a, ft};
    return v;
  endfunction

  function automatic logic [60:0] outs();
    return {bus_src, reg_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in,
            lo_in, mdr_sel, inc_pc, mem_read, mem_write, done, halted, alu_op, fault};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_oh(input string nm);
    check({nm, "_onehot0"}, 64'($onehot0(bus_src)), 64'd1);
  endtask

  // Inputs change just after posedge; outputs are compared at negedge.
  task automatic apply(input vec_t v, input string nm);
    run = v.run; mem_ready = v.rdy; ir = v.ir;
    @(negedge clock);
    check(nm, 64'(outs()), 64'(v.exp));
    check_oh(nm);
    @(posedge clock); #1;
  endtask

  task automatic run_tbl(input string nm);
    foreach (tbl[k]) apply(tbl[k], $sformatf("%s[%0d]", nm, k));
    tbl.delete();
  endtask

  task automatic fetch(input logic [31:0] i, input int waits);
    tbl.push_back(mk(1, 0, i, B(20), 0, MARI | INC | ZI, 0, 0));
    tbl.push_back(mk(1, 0, i, B(19), 0, PCI | RD, 0, 0));
    for (int w = 0; w < waits; w++) tbl.push_back(mk(1, 0, i, 0, 0, RD, 0, 0));
    tbl.push_back(mk(1, 1, i, 0, 0, RD | MDRI | SEL, 0, 0));
    tbl.push_back(mk(1, 0, i, B(21), 0, IRI, 0, 0));
  endtask

  task automatic do_reset();
    clear = 1'b1; run = 1'b0; mem_ready = 1'b0;
    @(posedge clock); #1;
    check("reset_outputs", 64'(outs()), 64'd0);
    check_oh("reset");
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    clear = 1'b1; run = 1'b0; mem_ready = 1'b0; ir = I_ADD;
    @(posedge clock); #1;
    do_reset();

    // ADD with run dropped in T4, then LD, MUL, ALU-imm, NOP, ST back to back
    tbl.push_back(mk(0, 0, I_ADD, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, I_ADD, 0, 0, 0, 0, 0));
    fetch(I_ADD, 0);
    tbl.push_back(mk(1, 0, I_ADD, B(2), 0, YI, 0, 0));
    tbl.push_back(mk(0, 0, I_ADD, B(3), 0, ZI, 5'h00, 0));
    tbl.push_back(mk(0, 0, I_ADD, B(19), 16'h0002, DN, 0, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 0, I_LD, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, I_LD, 0, 0, 0, 0, 0));
    fetch(I_LD, 0);
    tbl.push_back(mk(1, 0, I_LD, B(2), 0, YI, 0, 0));
    tbl.push_back(mk(1, 0, I_LD, B(23), 0, ZI, 5'h00, 0));
    tbl.push_back(mk(1, 0, I_LD, B(19), 0, MARI, 0, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 0, I_LD, 0, 0, RD, 0, 0));
    tbl.push_back(mk(1, 1, I_LD, 0, 0, RD | MDRI | SEL, 0, 0));
    tbl.push_back(mk(0, 0, I_LD, B(21), 16'h0010, DN, 0, 0));
    tbl.push_back(mk(1, 0, I_MUL, 0, 0, 0, 0, 0));
    fetch(I_MUL, 1);
    tbl.push_back(mk(1, 0, I_MUL, B(5), 0, YI, 0, 0));
    tbl.push_back(mk(1, 0, I_MUL, B(6), 0, ZI, 5'h0F, 0));
    tbl.push_back(mk(1, 0, I_MUL, B(19), 0, LOI, 0, 0));
    tbl.push_back(mk(1, 0, I_MUL, B(18), 0, HII | DN, 0, 0));
    fetch(I_ADDI, 0);
    tbl.push_back(mk(1, 0, I_ADDI, B(2), 0, YI, 0, 0));
    tbl.push_back(mk(1, 0, I_ADDI, B(23), 0, ZI, 5'h0C, 0));
    tbl.push_back(mk(1, 0, I_ADDI, B(19), 16'h0002, DN, 0, 0));
    fetch(I_NOP, 0);
    tbl.push_back(mk(1, 0, I_NOP, 0, 0, DN, 0, 0));
    fetch(I_ST, 0);
    tbl.push_back(mk(1, 0, I_ST, B(2), 0, YI, 0, 0));
    tbl.push_back(mk(1, 0, I_ST, B(23), 0, ZI, 5'h00, 0));
    tbl.push_back(mk(1, 0, I_ST, B(19), 0, MARI, 0, 0));
    tbl.push_back(mk(1, 0, I_ST, B(4), 0, MDRI, 0, 0));
    tbl.push_back(mk(0, 1, I_ST, 0, 0, WR | DN, 0, 0));
    tbl.push_back(mk(0, 0, I_ST, 0, 0, 0, 0, 0));
    run_tbl("prog");

    // Illegal opcode: halted with fault 01 the cycle after T3
    do_reset();
    tbl.push_back(mk(1, 0, I_BAD, 0, 0, 0, 0, 0));
    fetch(I_BAD, 0);
    tbl.push_back(mk(1, 0, I_BAD, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, I_BAD, 0, 0, HLT, 0, 2'b01));
    tbl.push_back(mk(1, 0, I_BAD, 0, 0, HLT, 0, 2'b01));
    run_tbl("illegal");

    // HALT opcode: halted, no fault
    do_reset();
    tbl.push_back(mk(1, 0, I_HALT, 0, 0, 0, 0, 0));
    fetch(I_HALT, 0);
    tbl.push_back(mk(1, 0, I_HALT, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, I_HALT, 0, 0, HLT, 0, 2'b00));
    run_tbl("halt");

    // ST with mem_ready stuck low: write held WAIT_LIMIT cycles then timeout
    do_reset();
    tbl.push_back(mk(1, 0, I_ST, 0, 0, 0, 0, 0));
    fetch(I_ST, 0);
    tbl.push_back(mk(1, 0, I_ST, B(2), 0, YI, 0, 0));
    tbl.push_back(mk(1, 0, I_ST, B(23), 0, ZI, 0, 0));
    tbl.push_back(mk(1, 0, I_ST, B(19), 0, MARI, 0, 0));
    tbl.push_back(mk(1, 0, I_ST, B(4), 0, MDRI, 0, 0));
    run_tbl("st_to");
    n = 0;
    mem_ready = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      if (mem_write !== 1'b1) break;
      n++;
      @(posedge clock); #1;
    end
    check("timeout_write_cycles", 64'(n), 64'd255);
    check("timeout_state", 64'(outs()), 64'(mk(1, 0, I_ST, 0, 0, HLT, 0, 2'b10).exp));
    @(posedge clock); #1;
    for (int k = 0; k < 4; k++)
      apply(mk(1, 1, I_ADD, 0, 0, HLT, 0, 2'b10), $sformatf("timeout_hold[%0d]", k));
    do_reset();

    // Asynchronous clear in T1W, then IDLE until run returns
    tbl.push_back(mk(1, 0, I_ADD, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, I_ADD, B(20), 0, MARI | INC | ZI, 0, 0));
    tbl.push_back(mk(1, 0, I_ADD, B(19), 0, PCI | RD, 0, 0));
    run_tbl("clr_pre");
    mem_ready = 1'b0;
    @(negedge clock);
    check("clr_t1w_read", 64'(outs()), 64'(mk(1, 0, I_ADD, 0, 0, RD, 0, 0).exp));
    #2 clear = 1'b1;
    #1 check("clr_async_zero", 64'(outs()), 64'd0);
    @(posedge clock); #1;
    clear = 1'b0;
    tbl.push_back(mk(0, 0, I_ADD, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, I_ADD, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, I_ADD, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, I_ADD, B(20), 0, MARI | INC | ZI, 0, 0));
    run_tbl("clr_post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
